sram_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port sync-read sram between NUM_REQ requesters
//  (matcher, encoder read/write sequencer, output copy path). Per-requester req/lock handshake;

---
 rtl/sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one single-port, synchronous-read SRAM
// between NUM_REQ requesters.
//
// A requester holds req until its access is accepted. While it also holds
// lock, it keeps the grant for a burst of up to MAX_BURST accesses.
// Read data is passed straight through from the SRAM. rvalid tags that data
// with the requester that issued the read, one cycle after the access.
//
// state | meaning
// IDLE  | no owner, no sram access; pick next owner round-robin from rr_ptr
// GRANT | owner holds gnt; one sram access per cycle while req[owner] is high
module sram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // One spare count value keeps the width non-zero when MAX_BURST is 1.
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [PTR_W-1:0]   owner_q,     owner_d;
    logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [NUM_REQ-1:0] rvalid_q,    rvalid_d;

    logic               access;
    logic [PTR_W-1:0]   pick;
    logic               found;
    int                 scan_idx;

    // The owner performs an access in every GRANT cycle in which it still requests.
    assign access = (state_q == GRANT) && req[owner_q];

    // Round-robin search: the first requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req[PTR_W'(scan_idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state logic for the grant FSM, the burst counter and the read tag.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        rvalid_d    = '0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    owner_d        = pick;
                    gnt_d[pick]    = 1'b1;
                    burst_cnt_d    = '0;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if (access) begin
                    rvalid_d[owner_q] = ~we[owner_q];
                    burst_cnt_d       = burst_cnt_q + 1'b1;
                end
                // Release if the owner stopped requesting, is not locking, or has used up its burst.
                if (!access || !lock[owner_q] ||
                    (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    // The owner just released drops to the lowest priority.
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any grant in progress and any pending rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = sram_dout;
    assign sram_cs   = access;
    assign sram_we   = access & we[owner_q];
    assign sram_addr = addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign sram_din  = din[owner_q*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a scoreboard: the stimulus pushes the
// expected SRAM accesses and read returns into queues. A monitor pops and
// compares them whenever the DUT drives sram_cs or rvalid.
module tb_sram_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req, lock, we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  din;
    logic [NR-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              sram_cs, sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_din;
    logic [DW-1:0]     sram_dout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NR-1:0] g;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    typedef struct packed {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];

    sram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read SRAM. Contents are 8'h10+addr, except that addr 3 holds 8'hA5.
    logic [DW-1:0] mem [16];
    bit            mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
            mem[3]   <= 8'hA5;
            mem_init = 1'b1;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    // Monitor: compare every SRAM access and every read return against the queues.
    always @(negedge clk) begin
        acc_t ea;
        rd_t  er;
        if (rst_n) begin
            if (sram_cs) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL access_unexpected got gnt=%b we=%b addr=%h din=%h", gnt, sram_we, sram_addr, sram_din);
                end else begin
                    ea = acc_q.pop_front();
                    if ({gnt, sram_we, sram_addr, sram_din} !== ea) begin
                        errors++;
                        $display("FAIL access got gnt=%b we=%b addr=%h din=%h want gnt=%b we=%b addr=%h din=%h",
                                 gnt, sram_we, sram_addr, sram_din, ea.g, ea.w, ea.a, ea.d);
                    end
                end
            end
            if (rvalid != '0) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected got rvalid=%b rdata=%h", rvalid, rdata);
                end else begin
                    er = rd_q.pop_front();
                    if ({rvalid, rdata} !== er) begin
                        errors++;
                        $display("FAIL read got rvalid=%b rdata=%h want rvalid=%b rdata=%h", rvalid, rdata, er.v, er.d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout, simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic void push_acc(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.g = NR'(1 << i);
        e.w = w;
        e.a = a;
        e.d = d;
        acc_q.push_back(e);
    endfunction

    function automatic void push_rd(input int i, input logic [DW-1:0] d);
        rd_t e;
        e.v = NR'(1 << i);
        e.d = d;
        rd_q.push_back(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    task automatic clear_inputs();
        req  = '0;
        lock = '0;
        we   = '0;
        addr = '0;
        din  = '0;
    endtask

    // Reset for one cycle; returns #1 into the first post-reset cycle (c0).
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_sram_cs", 32'(sram_cs), 32'h0);
        chk("reset_sram_we", 32'(sram_we), 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // T1: single read, addr 3
        req[0] = 1'b1;
        set_addr(0, 4'd3);
        push_acc(0, 1'b0, 4'd3, 8'h00);
        push_rd(0, 8'hA5);
        cyc();                                   // c1
        chk("t1_gnt_c1", 32'(gnt), 32'h1);
        chk("t1_cs_c1", 32'(sram_cs), 32'h1);
        cyc();                                   // c2
        req[0] = 1'b0;
        chk("t1_gnt_c2", 32'(gnt), 32'h0);
        chk("t1_rvalid_c2", 32'(rvalid), 32'h1);
        chk("t1_rdata_c2", 32'(rdata), 32'hA5);
        cyc();

        // T2: req0 and req2 together from rr_ptr=0, then rr_ptr must be 3
        do_reset();
        req[0] = 1'b1; set_addr(0, 4'd1);
        req[2] = 1'b1; set_addr(2, 4'd2);
        push_acc(0, 1'b0, 4'd1, 8'h00); push_rd(0, 8'h11);
        push_acc(2, 1'b0, 4'd2, 8'h00); push_rd(2, 8'h12);
        cyc();                                   // c1
        chk("t2_gnt0_c1", 32'(gnt), 32'h1);
        cyc();                                   // c2 idle
        req[0] = 1'b0;
        chk("t2_idle_c2", 32'(gnt), 32'h0);
        cyc();                                   // c3
        chk("t2_gnt2_c3", 32'(gnt), 32'h4);
        cyc();                                   // c4 idle
        req[2] = 1'b0;
        req[0] = 1'b1; set_addr(0, 4'd4);
        req[3] = 1'b1; set_addr(3, 4'd6);
        push_acc(3, 1'b0, 4'd6, 8'h00); push_rd(3, 8'h16);
        push_acc(0, 1'b0, 4'd4, 8'h00); push_rd(0, 8'h14);
        cyc();                                   // c5
        chk("t2_rrptr3_gnt3", 32'(gnt), 32'h8);
        cyc();                                   // c6
        req[3] = 1'b0;
        cyc();                                   // c7
        chk("t2_then_gnt0", 32'(gnt), 32'h1);
        cyc();
        req[0] = 1'b0;
        cyc();

        // T3: locked burst by req1 limited to 8 accesses, req2 served next
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1;
        req[2] = 1'b1; set_addr(2, 4'd9);
        for (int k = 1; k <= 8; k++) begin
            push_acc(1, 1'b0, 4'(k), 8'h00);
            push_rd(1, (k == 3) ? 8'hA5 : 8'h10 + 8'(k));
        end
        push_acc(2, 1'b0, 4'd9, 8'h00);
        push_rd(2, 8'h19);
        for (int k = 1; k <= 8; k++) begin
            cyc();                               // ck
            set_addr(1, 4'(k));
            chk("t3_burst_gnt1", 32'(gnt), 32'h2);
        end
        cyc();                                   // c9
        chk("t3_release", 32'(gnt), 32'h0);
        cyc();                                   // c10
        chk("t3_gnt2_next", 32'(gnt), 32'h4);
        cyc();                                   // c11
        req[1] = 1'b0; lock[1] = 1'b0; req[2] = 1'b0;
        chk("t3_done_idle", 32'(gnt), 32'h0);
        cyc();
        cyc();

        // T4: write then read back by req3
        do_reset();
        req[3] = 1'b1; we[3] = 1'b1; set_addr(3, 4'd5); din[3*DW +: DW] = 8'h3C;
        push_acc(3, 1'b1, 4'd5, 8'h3C);
        cyc();                                   // c1
        chk("t4_gnt3_write", 32'(gnt), 32'h8);
        cyc();                                   // c2
        chk("t4_no_rvalid_write", 32'(rvalid), 32'h0);
        we[3] = 1'b0;
        push_acc(3, 1'b0, 4'd5, 8'h3C);
        push_rd(3, 8'h3C);
        cyc();                                   // c3
        chk("t4_gnt3_read", 32'(gnt), 32'h8);
        cyc();                                   // c4
        req[3] = 1'b0;
        chk("t4_rdata", 32'(rdata), 32'h3C);
        cyc();

        // T5: reset during the 4th access of a locked burst by req2
        do_reset();
        req[1] = 1'b1; set_addr(1, 4'd7);
        push_acc(1, 1'b0, 4'd7, 8'h00); push_rd(1, 8'h17);
        cyc();                                   // c1
        chk("t5_gnt1", 32'(gnt), 32'h2);
        cyc();                                   // c2
        req[1] = 1'b0;
        req[2] = 1'b1; lock[2] = 1'b1; set_addr(2, 4'd8);
        for (int k = 0; k < 3; k++) push_acc(2, 1'b0, 4'd8, 8'h00);
        for (int k = 0; k < 2; k++) push_rd(2, 8'h18);
        cyc();                                   // c3
        chk("t5_gnt2", 32'(gnt), 32'h4);
        cyc();                                   // c4
        cyc();                                   // c5
        cyc();                                   // c6: 4th access
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_rvalid", 32'(rvalid), 32'h0);
        chk("t5_rst_cs", 32'(sram_cs), 32'h0);
        req[2] = 1'b0; lock[2] = 1'b0;
        cyc();                                   // c7
        rst_n = 1'b1;
        req[0] = 1'b1; set_addr(0, 4'd9);
        req[2] = 1'b1; set_addr(2, 4'd10);
        push_acc(0, 1'b0, 4'd9, 8'h00);  push_rd(0, 8'h19);
        push_acc(2, 1'b0, 4'd10, 8'h00); push_rd(2, 8'h1A);
        cyc();                                   // c8
        chk("t5_rr_restart0", 32'(gnt), 32'h1);
        cyc();                                   // c9
        req[0] = 1'b0;
        cyc();                                   // c10
        chk("t5_then_gnt2", 32'(gnt), 32'h4);
        cyc();
        req[2] = 1'b0;
        cyc();

        // T6: owner drops req mid-lock-burst, waiting req0 granted
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; set_addr(1, 4'd2);
        push_acc(1, 1'b0, 4'd2, 8'h00); push_rd(1, 8'h12);
        push_acc(1, 1'b0, 4'd2, 8'h00); push_rd(1, 8'h12);
        push_acc(0, 1'b0, 4'd4, 8'h00); push_rd(0, 8'h14);
        cyc();                                   // c1
        req[0] = 1'b1; set_addr(0, 4'd4);
        chk("t6_gnt1", 32'(gnt), 32'h2);
        cyc();                                   // c2
        cyc();                                   // c3
        req[1] = 1'b0;
        #1;
        chk("t6_drop_gnt_held", 32'(gnt), 32'h2);
        chk("t6_drop_no_cs", 32'(sram_cs), 32'h0);
        cyc();                                   // c4
        chk("t6_idle", 32'(gnt), 32'h0);
        cyc();                                   // c5
        chk("t6_gnt0", 32'(gnt), 32'h1);
        cyc();                                   // c6
        req[0] = 1'b0; lock[1] = 1'b0;
        cyc();
        cyc();
        cyc();

        chk("acc_queue_drained", 32'(acc_q.size()), 32'h0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
